aes_128_out_serializer: RTL and testbench



---
 rtl/aes_128_pkg.sv | 20 ++
 rtl/aes_128_block_fifo.sv | 67 ++++++
 rtl/aes_128_out_serializer.sv | 73 +++++++
 tb/tb_aes_128_out_serializer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/aes_128_pkg.sv
// Shared widths and word-slicing helper for the aes_128 output path.
package aes_128_pkg;

    localparam int AES_BLOCK_W         = 128;
    localparam int AES_WORD_W          = 32;
    localparam int AES_WORDS_PER_BLOCK = 4;
    localparam int AES_IDX_W           = $clog2(AES_WORDS_PER_BLOCK);

    typedef logic [AES_BLOCK_W-1:0] aes_block_t;
    typedef logic [AES_WORD_W-1:0]  aes_word_t;

    // Word 0 is the most significant word, matching hex print order.
    function automatic aes_word_t aes_word_sel(input aes_block_t blk,
                                               input logic [AES_IDX_W-1:0] idx);
        int base;
        base = AES_BLOCK_W - 1 - AES_WORD_W * int'(idx);
        return blk[base -: AES_WORD_W];
    endfunction

endpackage

// File: rtl/aes_128_block_fifo.sv
// DEPTH-entry register FIFO of 128-bit blocks with occupancy count and registered full.
module aes_128_block_fifo
    import aes_128_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  aes_block_t       din,
    output aes_block_t       head,
    output logic [CNT_W-1:0] count,
    output logic             full
);

    aes_block_t       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_nxt;
    logic             push_ok;
    logic             pop_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    assign pop_ok  = pop & (count != '0);
    assign push_ok = push & (!full | pop_ok);

    always_comb begin
        count_nxt = count;
        if (push_ok && !pop_ok) begin
            count_nxt = count + 1'b1;
        end else if (!push_ok && pop_ok) begin
            count_nxt = count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop_ok) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count_nxt;
            full  <= (count_nxt == CNT_W'(DEPTH));
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/aes_128_out_serializer.sv
// Buffers aes_128 ciphertext blocks and streams each as four 32-bit words over valid/ready.
module aes_128_out_serializer
    import aes_128_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             core_valid,
    input  aes_block_t       core_out,
    output aes_word_t        m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_last,
    output logic             full,
    output logic             overflow,
    input  logic             ovf_clr
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [AES_IDX_W-1:0] LAST_IDX = AES_IDX_W'(AES_WORDS_PER_BLOCK - 1);

    logic [AES_IDX_W-1:0] idx;
    logic [CNT_W-1:0]     count;
    aes_block_t           head;
    logic                 xfer;
    logic                 pop;
    logic                 push;
    logic                 drop;

    aes_128_block_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (core_out),
        .head  (head),
        .count (count),
        .full  (full)
    );

    // m_valid comes from registered occupancy only, so m_ready never reaches it.
    assign m_valid = (count != '0);
    assign m_last  = m_valid & (idx == LAST_IDX);
    assign m_data  = aes_word_sel(head, idx);

    assign xfer = m_valid & m_ready;
    assign pop  = xfer & (idx == LAST_IDX);
    assign push = core_valid & (!full | pop);
    assign drop = core_valid & full & !pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (xfer) begin
            idx <= pop ? '0 : idx + 1'b1;
        end
    end

    // A drop in the same cycle as a clear leaves the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_aes_128_out_serializer.sv
// Directed bench for aes_128_out_serializer with DEPTH=2.
module tb_aes_128_out_serializer;

    logic         clk;
    logic         rst_n;
    logic         core_valid;
    logic [127:0] core_out;
    logic [31:0]  m_data;
    logic         m_valid;
    logic         m_ready;
    logic         m_last;
    logic         full;
    logic         overflow;
    logic         ovf_clr;

    int n_cmp;
    int n_bad;

    aes_128_out_serializer #(
        .DEPTH (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .core_valid (core_valid),
        .core_out   (core_out),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_last     (m_last),
        .full       (full),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string        nm;
        logic         cv;
        logic [127:0] co;
        logic         rdy;
        logic         clr;
        logic         mv;
        logic         ml;
        logic         chk_md;
        logic [31:0]  md;
        logic         fl;
        logic         ov;
    } vec_t;

    vec_t vecs[$];

    localparam logic [127:0] FIPS = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] BLK_A = 128'h1;
    localparam logic [127:0] BLK_B = 128'h2;
    localparam logic [127:0] BLK_C = 128'h3;
    localparam logic [127:0] P1 = 128'ha0000000a0000001a0000002a0000003;
    localparam logic [127:0] P2 = 128'hb0000000b0000001b0000002b0000003;
    localparam logic [127:0] P3 = 128'hc0000000c0000001c0000002c0000003;
    localparam logic [127:0] PR = 128'hd0000000d0000001d0000002d0000003;
    localparam logic [127:0] PQ = 128'he0000000e0000001e0000002e0000003;

    function automatic logic [31:0] wd(input logic [127:0] b, input int i);
        return b[127-32*i -: 32];
    endfunction

    function automatic vec_t mk(input string nm, input logic cv, input logic [127:0] co,
                                input logic rdy, input logic clr, input logic mv,
                                input logic ml, input logic chk_md, input logic [31:0] md,
                                input logic fl, input logic ov);
        vec_t v;
        v.nm = nm; v.cv = cv; v.co = co; v.rdy = rdy; v.clr = clr;
        v.mv = mv; v.ml = ml; v.chk_md = chk_md; v.md = md; v.fl = fl; v.ov = ov;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp_v);
        end
    endtask

    task automatic chk_out(input string nm, input logic mv, input logic ml, input logic chk_md,
                           input logic [31:0] md, input logic fl, input logic ov);
        chk({nm, ".m_valid"}, 32'(m_valid), 32'(mv));
        chk({nm, ".m_last"}, 32'(m_last), 32'(ml));
        if (chk_md) chk({nm, ".m_data"}, m_data, md);
        chk({nm, ".full"}, 32'(full), 32'(fl));
        chk({nm, ".overflow"}, 32'(overflow), 32'(ov));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        core_valid = 1'b0;
        core_out = '0;
        m_ready = 1'b0;
        ovf_clr = 1'b0;

        // Test 1: FIPS-197 vector, m_ready high
        vecs.push_back(mk("fips_push", 1, FIPS, 1, 0, 0, 0, 1, 32'h0, 0, 0));
        vecs.push_back(mk("fips_w0", 0, '0, 1, 0, 1, 0, 1, 32'h3925841d, 0, 0));
        vecs.push_back(mk("fips_w1", 0, '0, 1, 0, 1, 0, 1, 32'h02dc09fb, 0, 0));
        vecs.push_back(mk("fips_w2", 0, '0, 1, 0, 1, 0, 1, 32'hdc118597, 0, 0));
        vecs.push_back(mk("fips_w3", 0, '0, 1, 0, 1, 1, 1, 32'h196a0b32, 0, 0));
        vecs.push_back(mk("fips_idle", 0, '0, 1, 0, 0, 0, 0, 32'h0, 0, 0));
        // Test 2: backpressure 1,0,0,1,1,0,1
        vecs.push_back(mk("bp_push", 1, FIPS, 0, 0, 0, 0, 0, 32'h0, 0, 0));
        vecs.push_back(mk("bp_c1", 0, '0, 1, 0, 1, 0, 1, 32'h3925841d, 0, 0));
        vecs.push_back(mk("bp_c2", 0, '0, 0, 0, 1, 0, 1, 32'h02dc09fb, 0, 0));
        vecs.push_back(mk("bp_c3", 0, '0, 0, 0, 1, 0, 1, 32'h02dc09fb, 0, 0));
        vecs.push_back(mk("bp_c4", 0, '0, 1, 0, 1, 0, 1, 32'h02dc09fb, 0, 0));
        vecs.push_back(mk("bp_c5", 0, '0, 1, 0, 1, 0, 1, 32'hdc118597, 0, 0));
        vecs.push_back(mk("bp_c6", 0, '0, 0, 0, 1, 1, 1, 32'h196a0b32, 0, 0));
        vecs.push_back(mk("bp_c7", 0, '0, 1, 0, 1, 1, 1, 32'h196a0b32, 0, 0));
        vecs.push_back(mk("bp_idle", 0, '0, 1, 0, 0, 0, 0, 32'h0, 0, 0));
        // Test 3: overflow with DEPTH=2
        vecs.push_back(mk("ovf_pa", 1, BLK_A, 0, 0, 0, 0, 0, 32'h0, 0, 0));
        vecs.push_back(mk("ovf_pb", 1, BLK_B, 0, 0, 1, 0, 1, 32'h0, 0, 0));
        vecs.push_back(mk("ovf_pc", 1, BLK_C, 0, 0, 1, 0, 1, 32'h0, 1, 0));
        vecs.push_back(mk("ovf_set", 0, '0, 0, 0, 1, 0, 1, 32'h0, 1, 1));
        vecs.push_back(mk("ovf_a0", 0, '0, 1, 0, 1, 0, 1, 32'h0, 1, 1));
        vecs.push_back(mk("ovf_a1", 0, '0, 1, 0, 1, 0, 1, 32'h0, 1, 1));
        vecs.push_back(mk("ovf_a2", 0, '0, 1, 0, 1, 0, 1, 32'h0, 1, 1));
        vecs.push_back(mk("ovf_a3", 0, '0, 1, 0, 1, 1, 1, 32'h1, 1, 1));
        vecs.push_back(mk("ovf_b0", 0, '0, 1, 0, 1, 0, 1, 32'h0, 0, 1));
        vecs.push_back(mk("ovf_b1", 0, '0, 1, 0, 1, 0, 1, 32'h0, 0, 1));
        vecs.push_back(mk("ovf_b2", 0, '0, 1, 0, 1, 0, 1, 32'h0, 0, 1));
        vecs.push_back(mk("ovf_b3", 0, '0, 1, 0, 1, 1, 1, 32'h2, 0, 1));
        vecs.push_back(mk("ovf_clr", 0, '0, 0, 1, 0, 0, 0, 32'h0, 0, 1));
        vecs.push_back(mk("ovf_cleared", 0, '0, 0, 0, 0, 0, 0, 32'h0, 0, 0));

        // Reset state
        tick();
        tick();
        chk_out("reset", 0, 0, 1, 32'h0, 0, 0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            chk_out(vecs[i].nm, vecs[i].mv, vecs[i].ml, vecs[i].chk_md, vecs[i].md,
                    vecs[i].fl, vecs[i].ov);
            core_valid = vecs[i].cv;
            core_out   = vecs[i].co;
            m_ready    = vecs[i].rdy;
            ovf_clr    = vecs[i].clr;
            tick();
        end
        core_valid = 1'b0;
        ovf_clr = 1'b0;

        // Test 4: full FIFO, push coincides with block-final pop
        m_ready = 1'b0;
        core_valid = 1'b1; core_out = P1; tick();
        core_out = P2; tick();
        core_valid = 1'b0;
        chk_out("sim_full", 1, 0, 1, wd(P1, 0), 1, 0);
        m_ready = 1'b1;
        for (int w = 0; w < 3; w++) begin
            chk("sim_p1_word", m_data, wd(P1, w));
            tick();
        end
        chk_out("sim_p1_last", 1, 1, 1, wd(P1, 3), 1, 0);
        core_valid = 1'b1; core_out = P3; tick();
        core_valid = 1'b0;
        chk_out("sim_after", 1, 0, 1, wd(P2, 0), 1, 0);
        for (int w = 0; w < 4; w++) begin
            chk("sim_p2_word", m_data, wd(P2, w));
            tick();
        end
        for (int w = 0; w < 4; w++) begin
            chk("sim_p3_word", m_data, wd(P3, w));
            chk("sim_p3_last", 32'(m_last), 32'(w == 3));
            tick();
        end
        chk_out("sim_drained", 0, 0, 0, 32'h0, 0, 0);

        // Overflow set and clear in the same cycle: set wins
        m_ready = 1'b0;
        core_valid = 1'b1; core_out = P1; tick();
        core_out = P2; tick();
        ovf_clr = 1'b1; core_out = P3; tick();
        core_valid = 1'b0;
        chk_out("ovf_prio", 1, 0, 1, wd(P1, 0), 1, 1);
        tick();
        ovf_clr = 1'b0;
        chk("ovf_prio_clr", 32'(overflow), 32'h0);
        m_ready = 1'b1;
        repeat (8) tick();
        chk_out("prio_drained", 0, 0, 0, 32'h0, 0, 0);

        // Test 5: reset after two words of a block
        core_valid = 1'b1; core_out = PR; tick();
        core_valid = 1'b0;
        chk("rst_w0", m_data, wd(PR, 0));
        tick();
        chk("rst_w1", m_data, wd(PR, 1));
        tick();
        chk("rst_w2_pre", m_data, wd(PR, 2));
        rst_n = 1'b0;
        #1;
        chk_out("rst_async", 0, 0, 1, 32'h0, 0, 0);
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            chk("rst_idle_valid", 32'(m_valid), 32'h0);
            tick();
        end
        core_valid = 1'b1; core_out = PQ; tick();
        core_valid = 1'b0;
        for (int w = 0; w < 4; w++) begin
            chk_out("rst_next_blk", 1, (w == 3), 1, wd(PQ, w), 0, 0);
            tick();
        end
        chk("rst_next_done", 32'(m_valid), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
